speck_write_sequencer: RTL and testbench

- Sole writer of the speck_map write port (speck_enable / speck_write_addr / speck_write), which feeds speck_display.
- Arbitrates three requesters:
  - full-map clear sweep, from game reset or game over;
  - playfield row fill/erase, from the line-clear effect;
  - single-cell writes, from the piece/sparkle logic.
- Serialises them into one write per clock.

---
 rtl/speck_pkg.sv | 25 ++
 rtl/speck_write_sequencer_if.sv | 39 +++
 rtl/speck_addr_gen.sv | 18 +
 rtl/speck_write_sequencer.sv | 156 +++++++++++++++
 tb/tb_speck_write_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/speck_pkg.sv
// Shared map geometry and sequencer state encoding for the speck_map write path.
package speck_pkg;

    localparam int MAP_WIDTH   = 14;
    localparam int NUM_ROWS    = 20;
    localparam int ROW_WIDTH   = 10;
    localparam int ROW_START_X = 3;
    localparam int ROW_START_Y = 1;
    localparam int MAP_DEPTH   = MAP_WIDTH * (NUM_ROWS + 2);

    localparam int ADDR_W    = 9;
    localparam int COL_W     = 4;
    localparam int ROW_IDX_W = 5;

    typedef logic [ADDR_W-1:0]    map_addr_t;
    typedef logic [COL_W-1:0]     col_t;
    typedef logic [ROW_IDX_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ROW
    } seq_state_t;

endpackage

// File: rtl/speck_write_sequencer_if.sv
// Request/handshake bundle between the clear, row and cell requesters and the speck_map write port.
interface speck_write_sequencer_if;
    import speck_pkg::*;

    logic      clear_start;
    logic      clear_busy;
    logic      clear_done;

    logic      row_start;
    row_t      row_idx;
    logic      row_val;
    logic      row_busy;
    logic      row_done;

    logic      cell_valid;
    logic      cell_ready;
    col_t      cell_x;
    row_t      cell_y;
    logic      cell_val;

    logic      speck_enable;
    map_addr_t speck_write_addr;
    logic      speck_write;

    modport master (
        output clear_start, row_start, row_idx, row_val,
               cell_valid, cell_x, cell_y, cell_val,
        input  clear_busy, clear_done, row_busy, row_done, cell_ready,
               speck_enable, speck_write_addr, speck_write
    );

    modport slave (
        input  clear_start, row_start, row_idx, row_val,
               cell_valid, cell_x, cell_y, cell_val,
        output clear_busy, clear_done, row_busy, row_done, cell_ready,
               speck_enable, speck_write_addr, speck_write
    );

endinterface

// File: rtl/speck_addr_gen.sv
// Playfield (x, y) to linear speck_map address; shared by the row-base and single-cell paths.
module speck_addr_gen
    import speck_pkg::*;
(
    input  col_t      x_i,
    input  row_t      y_i,
    output map_addr_t addr_o
);

    map_addr_t x_ext;
    map_addr_t y_ext;

    assign x_ext  = {{(ADDR_W-COL_W){1'b0}}, x_i};
    assign y_ext  = {{(ADDR_W-ROW_IDX_W){1'b0}}, y_i};
    assign addr_o = (y_ext + map_addr_t'(ROW_START_Y)) * map_addr_t'(MAP_WIDTH)
                  + map_addr_t'(ROW_START_X) + x_ext;

endmodule

// File: rtl/speck_write_sequencer.sv
// Sole writer of speck_map: serialises full-map clears, playfield row fills and single-cell
// writes into one registered write per clock.
module speck_write_sequencer
    import speck_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    speck_write_sequencer_if.slave bus
);

    seq_state_t state_q, state_d;
    logic       clear_pend_q, clear_pend_d;
    logic       row_pend_q, row_pend_d;
    row_t       row_idx_q, row_idx_d;
    logic       row_val_q, row_val_d;
    col_t       col_cnt_q, col_cnt_d;
    logic       en_q, en_d;
    map_addr_t  addr_q, addr_d;
    logic       data_q, data_d;
    logic       clear_done_q, clear_done_d;
    logic       row_done_q, row_done_d;

    logic       clear_busy;
    logic       row_busy;
    logic       cell_in_range;
    col_t       gen_x;
    row_t       gen_y;
    map_addr_t  gen_addr;

    assign clear_busy = clear_pend_q || (state_q == CLEAR);
    assign row_busy   = row_pend_q || (state_q == ROW);

    assign bus.clear_busy       = clear_busy;
    assign bus.row_busy         = row_busy;
    assign bus.cell_ready       = (state_q == IDLE) && !clear_pend_q && !row_pend_q;
    assign bus.clear_done       = clear_done_q;
    assign bus.row_done         = row_done_q;
    assign bus.speck_enable     = en_q;
    assign bus.speck_write_addr = addr_q;
    assign bus.speck_write      = data_q;

    // A pending row only matters in IDLE, where it outranks the cell path for the shared generator.
    assign gen_x = row_pend_q ? '0 : bus.cell_x;
    assign gen_y = row_pend_q ? row_idx_q : bus.cell_y;

    assign cell_in_range = (bus.cell_x < col_t'(ROW_WIDTH)) && (bus.cell_y < row_t'(NUM_ROWS));

    speck_addr_gen u_addr_gen (
        .x_i    (gen_x),
        .y_i    (gen_y),
        .addr_o (gen_addr)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch.
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        row_pend_d   = row_pend_q;
        row_idx_d    = row_idx_q;
        row_val_d    = row_val_q;
        col_cnt_d    = col_cnt_q;
        en_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        clear_done_d = 1'b0;
        row_done_d   = 1'b0;

        if (bus.clear_start && !clear_busy) begin
            clear_pend_d = 1'b1;
        end
        if (bus.row_start && !row_busy && (bus.row_idx < row_t'(NUM_ROWS))) begin
            row_pend_d = 1'b1;
            row_idx_d  = bus.row_idx;
            row_val_d  = bus.row_val;
        end

        unique case (state_q)
            IDLE: begin
                if (clear_pend_q) begin
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    en_d         = 1'b1;
                    addr_d       = '0;
                    data_d       = 1'b0;
                end else if (row_pend_q) begin
                    state_d    = ROW;
                    row_pend_d = 1'b0;
                    col_cnt_d  = '0;
                    en_d       = 1'b1;
                    addr_d     = gen_addr;
                    data_d     = row_val_q;
                end else if (bus.cell_valid && cell_in_range) begin
                    en_d   = 1'b1;
                    addr_d = gen_addr;
                    data_d = bus.cell_val;
                end
            end

            CLEAR: begin
                if (addr_q == map_addr_t'(MAP_DEPTH - 1)) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    en_d   = 1'b1;
                    addr_d = addr_q + map_addr_t'(1);
                    data_d = 1'b0;
                end
            end

            ROW: begin
                if (col_cnt_q == col_t'(ROW_WIDTH - 1)) begin
                    state_d    = IDLE;
                    row_done_d = 1'b1;
                    col_cnt_d  = '0;
                end else begin
                    col_cnt_d = col_cnt_q + col_t'(1);
                    en_d      = 1'b1;
                    addr_d    = addr_q + map_addr_t'(1);
                    data_d    = row_val_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b0;
            row_pend_q   <= 1'b0;
            row_idx_q    <= '0;
            row_val_q    <= 1'b0;
            col_cnt_q    <= '0;
            en_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= 1'b0;
            clear_done_q <= 1'b0;
            row_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the values held before the edge.
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            row_pend_q   <= row_pend_d;
            row_idx_q    <= row_idx_d;
            row_val_q    <= row_val_d;
            col_cnt_q    <= col_cnt_d;
            en_q         <= en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            clear_done_q <= clear_done_d;
            row_done_q   <= row_done_d;
        end
    end

endmodule

// File: tb/tb_speck_write_sequencer.sv
// Self-checking bench: expected write streams are built arithmetically from map geometry and
// compared against every observed speck_map write, along with done-pulse timing.
module tb_speck_write_sequencer;
    import speck_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    speck_write_sequencer_if bus ();

    speck_write_sequencer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_q[$];
    int obs_q[$];
    int clear_done_cnt = 0;
    int row_done_cnt   = 0;
    int clear_done_cyc = -1;
    int row_done_cyc   = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then sample the registered outputs 1 ns later.
    task automatic tick();
        @(posedge clk_in);
        cyc++;
        #1;
        if (bus.speck_enable === 1'b1)
            obs_q.push_back(int'(bus.speck_write_addr) * 2 + int'(bus.speck_write));
        if (bus.clear_done === 1'b1) begin
            clear_done_cnt++;
            clear_done_cyc = cyc;
        end
        if (bus.row_done === 1'b1) begin
            row_done_cnt++;
            row_done_cyc = cyc;
        end
    endtask

    function automatic int map_addr(input int x, input int y);
        return (y + ROW_START_Y) * MAP_WIDTH + ROW_START_X + x;
    endfunction

    task automatic reset_counts();
        clear_done_cnt = 0;
        row_done_cnt   = 0;
        clear_done_cyc = -1;
        row_done_cyc   = -1;
    endtask

    task automatic expect_clear();
        for (int a = 0; a < MAP_DEPTH; a++) exp_q.push_back(a * 2);
    endtask

    task automatic expect_row(input int idx, input int val);
        for (int c = 0; c < ROW_WIDTH; c++) exp_q.push_back(map_addr(c, idx) * 2 + val);
    endtask

    // Write words are encoded as addr*2+data; stop at the first divergence.
    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr2_data"}, obs_q[i], exp_q[i]);
            if (obs_q[i] != exp_q[i]) break;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_row_done(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (row_done_cnt > 0) break;
            tick();
        end
        if (row_done_cnt == 0) check({tag, "_row_done_timeout"}, 0, 1);
    endtask

    task automatic do_row(input int idx, input int val);
        int e0;
        string tag;
        tag = $sformatf("row%0d", idx);
        reset_counts();
        bus.row_start = 1'b1;
        bus.row_idx   = row_t'(idx);
        bus.row_val   = val[0];
        tick();
        e0 = cyc;
        bus.row_start = 1'b0;
        if (idx < NUM_ROWS) begin
            expect_row(idx, val);
            check({tag, "_busy_hi"}, bus.row_busy, 1);
            wait_row_done(tag, 40);
            check({tag, "_done_cyc"}, row_done_cyc, e0 + ROW_WIDTH + 1);
            tick();
            check({tag, "_busy_lo"}, bus.row_busy, 0);
            check({tag, "_done_cnt"}, row_done_cnt, 1);
        end else begin
            check({tag, "_busy_stays_lo"}, bus.row_busy, 0);
            repeat (15) tick();
            check({tag, "_no_done"}, row_done_cnt, 0);
        end
        compare_writes(tag);
    endtask

    initial begin
        int e0;
        int ready_hi;
        int xs[$];
        int ys[$];
        int vs[$];

        bus.clear_start = 1'b0;
        bus.row_start   = 1'b0;
        bus.row_idx     = '0;
        bus.row_val     = 1'b0;
        bus.cell_valid  = 1'b0;
        bus.cell_x      = '0;
        bus.cell_y      = '0;
        bus.cell_val    = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_enable", bus.speck_enable, 0);
        check("rst_addr", bus.speck_write_addr, 0);
        check("rst_data", bus.speck_write, 0);
        check("rst_clear_done", bus.clear_done, 0);
        check("rst_row_done", bus.row_done, 0);
        check("rst_clear_busy", bus.clear_busy, 0);
        check("rst_row_busy", bus.row_busy, 0);
        check("rst_cell_ready", bus.cell_ready, 1);
        rst_in = 1'b1;
        tick();

        // Full clear sweep
        reset_counts();
        bus.clear_start = 1'b1;
        tick();
        e0 = cyc;
        bus.clear_start = 1'b0;
        check("clr_busy_hi", bus.clear_busy, 1);
        expect_clear();
        for (int k = 0; k < 400 && clear_done_cnt == 0; k++) tick();
        check("clr_done_cyc", clear_done_cyc, e0 + MAP_DEPTH + 1);
        check("clr_busy_lo", bus.clear_busy, 0);
        tick();
        tick();
        check("clr_done_cnt", clear_done_cnt, 1);
        compare_writes("clr");

        // Rows: directed ends, random in-range, out-of-range
        do_row(0, 1);
        do_row(19, 0);
        repeat (4) do_row(int'($urandom_range(0, NUM_ROWS - 1)), int'($urandom_range(0, 1)));
        do_row(20, 1);
        do_row(int'($urandom_range(21, 31)), 0);

        // Simultaneous clear + row, with a cell held waiting behind both
        reset_counts();
        bus.clear_start = 1'b1;
        bus.row_start   = 1'b1;
        bus.row_idx     = 5'd5;
        bus.row_val     = 1'b1;
        tick();
        e0 = cyc;
        bus.clear_start = 1'b0;
        bus.row_start   = 1'b0;
        bus.cell_valid  = 1'b1;
        bus.cell_x      = 4'd9;
        bus.cell_y      = 5'd19;
        bus.cell_val    = 1'b1;
        expect_clear();
        expect_row(5, 1);
        exp_q.push_back(map_addr(9, 19) * 2 + 1);
        ready_hi = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (row_done_cnt > 0) break;
            if (bus.cell_ready === 1'b1) ready_hi++;
        end
        check("both_ready_low", ready_hi, 0);
        check("both_clr_done_cyc", clear_done_cyc, e0 + MAP_DEPTH + 1);
        check("both_row_done_cyc", row_done_cyc, e0 + MAP_DEPTH + 1 + ROW_WIDTH + 1);
        check("both_ready_after", bus.cell_ready, 1);
        tick();
        bus.cell_valid = 1'b0;
        tick();
        compare_writes("both");

        // Streaming cells: directed edge cases then random coordinates
        xs = '{0, 1, 9, 10};
        ys = '{0, 0, 19, 0};
        vs = '{1, 0, 1, 1};
        repeat (12) begin
            xs.push_back(int'($urandom_range(0, 15)));
            ys.push_back(int'($urandom_range(0, 31)));
            vs.push_back(int'($urandom_range(0, 1)));
        end
        for (int i = 0; i < xs.size(); i++) begin
            bus.cell_valid = 1'b1;
            bus.cell_x     = col_t'(xs[i]);
            bus.cell_y     = row_t'(ys[i]);
            bus.cell_val   = vs[i][0];
            check("cell_ready_stream", bus.cell_ready, 1);
            if (xs[i] < ROW_WIDTH && ys[i] < NUM_ROWS)
                exp_q.push_back(map_addr(xs[i], ys[i]) * 2 + vs[i]);
            tick();
        end
        bus.cell_valid = 1'b0;
        tick();
        compare_writes("cells");

        // Reset asserted mid-clear at address 100
        reset_counts();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bus.speck_enable === 1'b1 && bus.speck_write_addr == map_addr_t'(100)) break;
        end
        for (int a = 0; a <= 100; a++) exp_q.push_back(a * 2);
        compare_writes("partial_clr");
        #2;
        rst_in = 1'b0;
        #1;
        check("mid_rst_enable", bus.speck_enable, 0);
        check("mid_rst_addr", bus.speck_write_addr, 0);
        check("mid_rst_data", bus.speck_write, 0);
        check("mid_rst_clear_busy", bus.clear_busy, 0);
        check("mid_rst_clear_done", bus.clear_done, 0);
        repeat (2) tick();
        rst_in = 1'b1;
        repeat (20) tick();
        check("mid_rst_no_done", clear_done_cnt, 0);
        check("mid_rst_ready", bus.cell_ready, 1);
        check("mid_rst_no_writes", obs_q.size(), 0);
        obs_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
